// File: rtl/magnetron_pkg.sv
// Shared types, constants and load-clamp helpers for the magnetron sequencer.
package magnetron_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReady = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned PowerMaxDef   = 10;
  localparam logic [3:0]  BcdDigitMax   = 4'd9;
  localparam logic [3:0]  BcdSecTensMax = 4'd5;
  localparam logic [15:0] MmssZero      = 16'h0000;

  // Force every digit into a legal BCD MM:SS value.
  function automatic logic [15:0] clamp_mmss(input logic [15:0] t);
    logic [15:0] r;
    r[15:12] = (t[15:12] > BcdDigitMax)   ? BcdDigitMax   : t[15:12];
    r[11:8]  = (t[11:8]  > BcdDigitMax)   ? BcdDigitMax   : t[11:8];
    r[7:4]   = (t[7:4]   > BcdSecTensMax) ? BcdSecTensMax : t[7:4];
    r[3:0]   = (t[3:0]   > BcdDigitMax)   ? BcdDigitMax   : t[3:0];
    return r;
  endfunction

  // Power 0 means "lowest", anything above the window length saturates.
  function automatic logic [3:0] clamp_power(input logic [3:0] p, input logic [3:0] pmax);
    logic [3:0] r;
    if (p == 4'd0) begin
      r = 4'd1;
    end else if (p > pmax) begin
      r = pmax;
    end else begin
      r = p;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational BCD MM:SS decrement by one second, saturating at 00:00.
module bcd_mmss_dec
  import magnetron_pkg::*;
(
  input  logic [15:0] value_i,
  output logic [15:0] value_o,
  output logic        is_zero_o
);

  // Borrow ripples S ones -> S tens -> M ones -> M tens.
  always_comb begin
    value_o = value_i;
    if (value_i == MmssZero) begin
      value_o = MmssZero;
    end else if (value_i[3:0] != 4'd0) begin
      value_o[3:0] = value_i[3:0] - 4'd1;
    end else begin
      value_o[3:0] = BcdDigitMax;
      if (value_i[7:4] != 4'd0) begin
        value_o[7:4] = value_i[7:4] - 4'd1;
      end else begin
        value_o[7:4] = BcdSecTensMax;
        if (value_i[11:8] != 4'd0) begin
          value_o[11:8] = value_i[11:8] - 4'd1;
        end else begin
          value_o[11:8]  = BcdDigitMax;
          value_o[15:12] = value_i[15:12] - 4'd1;
        end
      end
    end
  end

  assign is_zero_o = (value_o == MmssZero);

endmodule

// File: rtl/magnetron_sequencer.sv
// Cooking-cycle sequencer: BCD countdown, power duty-cycling and door interlock.
module magnetron_sequencer
  import magnetron_pkg::*;
#(
  parameter int unsigned BEEP_TICKS = 3,
  parameter int unsigned POWER_MAX  = PowerMaxDef
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        load,
  input  logic [15:0] time_in,
  input  logic [3:0]  power_in,
  output logic        mag_on,
  output logic [15:0] time_left,
  output logic [2:0]  state,
  output logic        done_beep
);

  localparam logic [3:0] PowerMaxL  = 4'(POWER_MAX);
  localparam logic [3:0] BeepTicksL = 4'(BEEP_TICKS);

  state_e      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [3:0]  power_q, power_d;
  logic [3:0]  phase_q, phase_d;
  logic [3:0]  beep_q, beep_d;
  logic        start_prev_q, stop_prev_q, clear_prev_q;

  logic        start_ev, stop_ev, clear_ev;
  logic [15:0] load_time, dec_time;
  logic [3:0]  load_power;
  logic        dec_zero;

  // Falling edges against the registered previous level; a held button fires once.
  assign start_ev = start_prev_q & ~startn;
  assign stop_ev  = stop_prev_q & ~stopn;
  assign clear_ev = clear_prev_q & ~clearn;

  assign load_time  = clamp_mmss(time_in);
  assign load_power = clamp_power(power_in, PowerMaxL);

  bcd_mmss_dec u_dec (
    .value_i   (time_q),
    .value_o   (dec_time),
    .is_zero_o (dec_zero)
  );

  // State and datapath registers; buttons reset to released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      time_q       <= MmssZero;
      power_q      <= PowerMaxL;
      phase_q      <= 4'd0;
      beep_q       <= 4'd0;
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      power_q      <= power_d;
      phase_q      <= phase_d;
      beep_q       <= beep_d;
      start_prev_q <= startn;
      stop_prev_q  <= stopn;
      clear_prev_q <= clearn;
    end
  end

  // Next-state logic; priority clear > stop > door open > start > tick, load lowest.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    power_d = power_q;
    phase_d = phase_q;
    beep_d  = beep_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          time_d  = load_time;
          power_d = load_power;
          if (load_time != MmssZero) state_d = StReady;
        end
      end
      StReady: begin
        if (clear_ev || stop_ev) begin
          state_d = StIdle;
          time_d  = MmssZero;
        end else if (start_ev && door_closed) begin
          state_d = StCook;
          phase_d = 4'd0;
        end else if (load) begin
          time_d  = load_time;
          power_d = load_power;
          if (load_time == MmssZero) state_d = StIdle;
        end
      end
      StCook: begin
        if (clear_ev) begin
          state_d = StIdle;
          time_d  = MmssZero;
        end else if (stop_ev || !door_closed) begin
          state_d = StPause;
        end else if (tick) begin
          time_d  = dec_time;
          phase_d = (phase_q == PowerMaxL - 4'd1) ? 4'd0 : phase_q + 4'd1;
          if (dec_zero) begin
            state_d = StDone;
            beep_d  = 4'd0;
          end
        end
      end
      StPause: begin
        if (clear_ev || stop_ev) begin
          state_d = StIdle;
          time_d  = MmssZero;
        end else if (start_ev && door_closed) begin
          state_d = StCook;
        end
      end
      StDone: begin
        if (tick && (beep_q < BeepTicksL)) beep_d = beep_q + 4'd1;
        if (clear_ev || stop_ev || start_ev) begin
          state_d = StIdle;
          time_d  = MmssZero;
        end else if (load) begin
          time_d  = load_time;
          power_d = load_power;
          state_d = (load_time != MmssZero) ? StReady : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Door term is deliberately combinational so the interlock cuts power without a clock.
  assign mag_on    = (state_q == StCook) & (phase_q < power_q) & door_closed;
  assign done_beep = (state_q == StDone) & (beep_q < BeepTicksL);
  assign time_left = time_q;
  assign state     = state_q;

endmodule

// File: tb/tb_magnetron_sequencer.sv
// Directed self-checking bench for magnetron_sequencer.
module tb_magnetron_sequencer;

  logic        clk, resetn, tick, startn, stopn, clearn, door_closed, load;
  logic [15:0] time_in;
  logic [3:0]  power_in;
  logic        mag_on, done_beep;
  logic [15:0] time_left;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  magnetron_sequencer #(
    .BEEP_TICKS (3),
    .POWER_MAX  (10)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tick        (tick),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .load        (load),
    .time_in     (time_in),
    .power_in    (power_in),
    .mag_on      (mag_on),
    .time_left   (time_left),
    .state       (state),
    .done_beep   (done_beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] t, input logic [3:0] p);
    load = 1'b1; time_in = t; power_in = p;
    cyc();
    load = 1'b0;
  endtask

  task automatic press_start();
    startn = 1'b0; cyc(); startn = 1'b1; cyc();
  endtask

  task automatic press_stop();
    stopn = 1'b0; cyc(); stopn = 1'b1; cyc();
  endtask

  task automatic press_clear();
    clearn = 1'b0; cyc(); clearn = 1'b1; cyc();
  endtask

  int         entries;
  logic [2:0] prev_state;

  initial begin
    resetn = 1'b0; tick = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; load = 1'b0; time_in = 16'h0; power_in = 4'd0;
    #12;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_time", time_left, 16'h0000);
    chk("rst_mag", 16'(mag_on), 16'd0);
    chk("rst_beep", 16'(done_beep), 16'd0);
    resetn = 1'b1;
    cyc();

    // Basic cook at full power.
    do_load(16'h0003, 4'd10);
    chk("basic_ready", 16'(state), 16'd1);
    chk("basic_load_time", time_left, 16'h0003);
    startn = 1'b0; cyc();
    chk("basic_cook", 16'(state), 16'd2);
    chk("basic_mag_start", 16'(mag_on), 16'd1);
    startn = 1'b1; cyc();
    pulse_tick();
    chk("basic_t1", time_left, 16'h0002);
    chk("basic_mag1", 16'(mag_on), 16'd1);
    pulse_tick();
    chk("basic_t2", time_left, 16'h0001);
    chk("basic_mag2", 16'(mag_on), 16'd1);
    pulse_tick();
    chk("basic_t3", time_left, 16'h0000);
    chk("basic_done", 16'(state), 16'd4);
    chk("basic_mag_off", 16'(mag_on), 16'd0);
    chk("beep_entry", 16'(done_beep), 16'd1);
    pulse_tick();
    chk("beep_tick1", 16'(done_beep), 16'd1);
    pulse_tick();
    chk("beep_tick2", 16'(done_beep), 16'd1);
    pulse_tick();
    chk("beep_tick3", 16'(done_beep), 16'd0);
    press_clear();
    chk("done_clear", 16'(state), 16'd0);

    // Duty cycle at power 3: on for phases 0..2 of each 10-tick window.
    do_load(16'h0020, 4'd3);
    press_start();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("duty_ph%0d", i), 16'(mag_on), (i < 3) ? 16'd1 : 16'd0);
      pulse_tick();
    end
    chk("duty_time", time_left, 16'h0010);
    chk("duty_wrap_mag", 16'(mag_on), 16'd1);

    // Door interlock: phase 1 when the door opens.
    pulse_tick();
    chk("door_pre_time", time_left, 16'h0009);
    door_closed = 1'b0;
    #1;
    chk("door_mag_comb", 16'(mag_on), 16'd0);
    cyc();
    chk("door_pause", 16'(state), 16'd3);
    pulse_tick();
    pulse_tick();
    chk("door_frozen", time_left, 16'h0009);
    door_closed = 1'b1;
    startn = 1'b0; cyc();
    chk("resume_state", 16'(state), 16'd2);
    chk("resume_time", time_left, 16'h0009);
    chk("resume_mag", 16'(mag_on), 16'd1);
    startn = 1'b1; cyc();
    pulse_tick();
    chk("resume_ph2_mag", 16'(mag_on), 16'd1);
    pulse_tick();
    chk("resume_ph3_mag", 16'(mag_on), 16'd0);
    chk("resume_time2", time_left, 16'h0007);

    // Start and stop together in PAUSE: stop wins.
    press_stop();
    chk("stop_pause", 16'(state), 16'd3);
    startn = 1'b0; stopn = 1'b0; cyc();
    chk("prio_idle", 16'(state), 16'd0);
    chk("prio_time", time_left, 16'h0000);
    startn = 1'b1; stopn = 1'b1; cyc();

    // Clamping of time and power.
    do_load(16'h0F7A, 4'd0);
    chk("clamp_time", time_left, 16'h0959);
    chk("clamp_ready", 16'(state), 16'd1);
    press_start();
    chk("pow1_ph0_mag", 16'(mag_on), 16'd1);
    pulse_tick();
    chk("pow1_ph1_mag", 16'(mag_on), 16'd0);
    chk("pow1_time", time_left, 16'h0958);
    press_clear();
    chk("cook_clear", 16'(state), 16'd0);

    do_load(16'h1000, 4'd15);
    press_start();
    pulse_tick();
    chk("borrow_1000", time_left, 16'h0959);
    chk("pow15_mag", 16'(mag_on), 16'd1);
    press_clear();
    do_load(16'h0100, 4'd10);
    press_start();
    pulse_tick();
    chk("borrow_0100", time_left, 16'h0059);
    press_clear();

    do_load(16'h0000, 4'd5);
    chk("zero_load_idle", 16'(state), 16'd0);

    // Start with door open is ignored; a held start gives one COOK entry.
    do_load(16'h0005, 4'd10);
    door_closed = 1'b0;
    press_start();
    chk("door_open_start", 16'(state), 16'd1);
    door_closed = 1'b1;
    cyc();
    entries = 0;
    prev_state = state;
    startn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) stopn = 1'b0;
      if (i == 6) stopn = 1'b1;
      cyc();
      if (state == 3'd2 && prev_state != 3'd2) entries++;
      prev_state = state;
    end
    chk("hold_entries", 16'(entries), 16'd1);
    chk("hold_paused", 16'(state), 16'd3);
    chk("hold_time", time_left, 16'h0005);
    startn = 1'b1; cyc();
    press_start();
    chk("hold_resume", 16'(state), 16'd2);

    // Async reset mid-cook.
    pulse_tick();
    chk("prereset_time", time_left, 16'h0004);
    chk("prereset_mag", 16'(mag_on), 16'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_mag", 16'(mag_on), 16'd0);
    chk("areset_state", 16'(state), 16'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    chk("post_reset_state", 16'(state), 16'd0);
    chk("post_reset_time", time_left, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
